// File: rtl/regfile_scanner.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scanner
// Brief    : Walks a latched register-address range through the core's
//            decoupled read port and streams (addr, data) beats out through
//            a small FIFO on a ready/valid interface.
// Options  : define SCANNER_CHECKSUM_EN to add a running-sum checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scanner #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              read_addr_valid,
    input  logic              read_addr_ready,
    output logic [ADDR_W-1:0] read_addr_bits,
    input  logic              read_data_valid,
    output logic              read_data_ready,
    input  logic [DATA_W-1:0] read_data_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
`ifdef SCANNER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cur;
    logic [ADDR_W:0]     remaining;
    logic [ADDR_W-1:0]   span;

    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                accept_start;
    logic                addr_hs;
    logic                push;
    logic                pop;

    assign span         = last_addr - first_addr;
    assign accept_start = (state == S_IDLE) && start;
    assign addr_hs      = read_addr_valid && read_addr_ready;
    assign push         = ((state == S_REQ) && addr_hs && read_data_valid) ||
                          ((state == S_WAIT) && read_data_valid);
    assign pop          = out_valid && out_ready;

    assign read_addr_bits = cur;
    assign out_valid      = (count != '0);
    // Mask the head so idle/reset outputs read as zero without resetting storage.
    assign out_addr       = out_valid ? fifo_addr[rd_ptr] : '0;
    assign out_data       = out_valid ? fifo_data[rd_ptr] : '0;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; REQ gates on the registered FIFO count.
    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        read_addr_valid = 1'b0;
        read_data_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                busy            = 1'b1;
                read_addr_valid = (count < DEPTH_C);
                read_data_ready = read_addr_valid;
                if (push)         state_nxt = (remaining == REM_ONE) ? S_DRAIN : S_REQ;
                else if (addr_hs) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy            = 1'b1;
                read_data_ready = 1'b1;
                if (push) state_nxt = (remaining == REM_ONE) ? S_DRAIN : S_REQ;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (count == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Range walker: current address and reads still to be issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= '0;
            remaining <= '0;
        end else if (accept_start) begin
            cur       <= first_addr;
            remaining <= {1'b0, span} + REM_ONE;
        end else if (push) begin
            cur       <= cur + 1'b1;
            remaining <= remaining - REM_ONE;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cur;
            fifo_data[wr_ptr] <= read_data_bits;
        end
    end

`ifdef SCANNER_CHECKSUM_EN
    // Running sum of pushed words; naturally holds after the last push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            checksum <= '0;
        else if (accept_start) checksum <= '0;
        else if (push)         checksum <= checksum + read_data_bits;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scanner
// Brief    : Directed self-checking bench for regfile_scanner with a small
//            register-file core model (r[i] = 0x100 + i).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scanner;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              busy;
    logic              done;
    logic              read_addr_valid;
    logic              read_addr_ready;
    logic [ADDR_W-1:0] read_addr_bits;
    logic              read_data_valid;
    logic              read_data_ready;
    logic [DATA_W-1:0] read_data_bits;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
`ifdef SCANNER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    regfile_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .first_addr      (first_addr),
        .last_addr       (last_addr),
        .busy            (busy),
        .done            (done),
        .read_addr_valid (read_addr_valid),
        .read_addr_ready (read_addr_ready),
        .read_addr_bits  (read_addr_bits),
        .read_data_valid (read_data_valid),
        .read_data_ready (read_data_ready),
        .read_data_bits  (read_data_bits),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_data        (out_data)
`ifdef SCANNER_CHECKSUM_EN
        ,
        .checksum        (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Core model: mode 0 answers in the handshake cycle, mode 1 answers
    // two cycles after the address handshake with one read outstanding.
    logic              mode = 1'b0;
    logic              pending = 1'b0;
    logic [1:0]        dly = 2'd0;
    logic [ADDR_W-1:0] paddr = '0;

    assign read_addr_ready = (mode == 1'b0) ? 1'b1 : !pending;
    assign read_data_valid = (mode == 1'b0) ? read_addr_valid : (pending && dly == 2'd0);
    assign read_data_bits  = 32'h100 + {28'h0, ((mode == 1'b0) ? read_addr_bits : paddr)};

    always @(posedge clk) begin
        if (mode == 1'b0) begin
            pending <= 1'b0;
        end else if (pending) begin
            if (dly != 2'd0)          dly <= dly - 2'd1;
            else if (read_data_ready) pending <= 1'b0;
        end else if (read_addr_valid && read_addr_ready) begin
            pending <= 1'b1;
            dly     <= 2'd2;
            paddr   <= read_addr_bits;
        end
    end

    // Output and event monitor.
    logic [ADDR_W+DATA_W-1:0] beats[$];
    int done_cnt = 0;
    int reads_issued = 0;

    always @(posedge clk) begin
        if (out_valid && out_ready) beats.push_back({out_addr, out_data});
        if (done) done_cnt++;
        if (read_addr_valid && read_addr_ready) reads_issued++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic do_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        @(negedge clk);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Returns cycles from the start cycle to the done cycle (19 for 16 regs).
    task automatic wait_done(input int budget, output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, read_addr_valid, read_data_ready, out_valid} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {busy, done, read_addr_valid, read_data_ready, out_valid});
        else pass_cnt++;
        total_cnt++;
        if (out_addr !== 4'h0) $display("FAIL reset_out_addr got=%h exp=0", out_addr);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", out_data);
        else pass_cnt++;
        total_cnt++;
        if (read_addr_bits !== 4'h0) $display("FAIL reset_read_addr got=%h exp=0", read_addr_bits);
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_full_scan();
        int cyc;
        int d0;
        logic [ADDR_W-1:0] a;
        mode = 1'b0;
        out_ready = 1'b1;
        beats.delete();
        d0 = done_cnt;
        do_start(4'd0, 4'd15);
        wait_done(100, cyc);
        total_cnt++;
        if (cyc != 19) $display("FAIL full_latency got=%0d exp=19", cyc);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, busy} !== 2'b00) $display("FAIL full_done_pulse got=%b exp=00", {done, busy});
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL full_done_count got=%0d exp=1", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (beats.size() != 16) $display("FAIL full_beat_count got=%0d exp=16", beats.size());
        else pass_cnt++;
        for (int i = 0; i < 16 && i < beats.size(); i++) begin
            a = 4'(i);
            total_cnt++;
            if (beats[i] !== {a, 32'h100 + {28'h0, a}})
                $display("FAIL full_beat%0d got=%h exp=%h", i, beats[i], {a, 32'h100 + {28'h0, a}});
            else pass_cnt++;
        end
`ifdef SCANNER_CHECKSUM_EN
        total_cnt++;
        if (checksum !== 32'h1078) $display("FAIL full_checksum got=%h exp=00001078", checksum);
        else pass_cnt++;
`endif
    endtask

    task automatic test_wrap();
        int cyc;
        int d0;
        logic [ADDR_W-1:0] a;
        beats.delete();
        d0 = done_cnt;
        do_start(4'd14, 4'd1);
        wait_done(100, cyc);
        @(negedge clk);
        total_cnt++;
        if (beats.size() != 4) $display("FAIL wrap_beat_count got=%0d exp=4", beats.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            a = 4'(14 + i);
            total_cnt++;
            if (beats[i] !== {a, 32'h100 + {28'h0, a}})
                $display("FAIL wrap_beat%0d got=%h exp=%h", i, beats[i], {a, 32'h100 + {28'h0, a}});
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL wrap_done_count got=%0d exp=1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int cyc;
        int r0;
        logic [ADDR_W-1:0] a;
        beats.delete();
        out_ready = 1'b0;
        r0 = reads_issued;
        do_start(4'd0, 4'd7);
        repeat (9) @(negedge clk);
        total_cnt++;
        if (reads_issued - r0 != 4) $display("FAIL bp_reads got=%0d exp=4", reads_issued - r0);
        else pass_cnt++;
        total_cnt++;
        if ({read_addr_valid, out_valid, busy} !== 3'b011)
            $display("FAIL bp_stall got=%b exp=011", {read_addr_valid, out_valid, busy});
        else pass_cnt++;
        out_ready = 1'b1;
        wait_done(100, cyc);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL bp_done got=%b exp=1", done);
        else pass_cnt++;
        total_cnt++;
        if (beats.size() != 8) $display("FAIL bp_beat_count got=%0d exp=8", beats.size());
        else pass_cnt++;
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            a = 4'(i);
            total_cnt++;
            if (beats[i] !== {a, 32'h100 + {28'h0, a}})
                $display("FAIL bp_beat%0d got=%h exp=%h", i, beats[i], {a, 32'h100 + {28'h0, a}});
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_delay();
        int cyc;
        int r0;
        beats.delete();
        mode = 1'b1;
        out_ready = 1'b1;
        r0 = reads_issued;
        do_start(4'd5, 4'd5);
        total_cnt++;
        if (read_addr_valid !== 1'b1) $display("FAIL dly_req got=%b exp=1", read_addr_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({read_addr_valid, read_data_ready, busy} !== 3'b011)
            $display("FAIL dly_wait got=%b exp=011", {read_addr_valid, read_data_ready, busy});
        else pass_cnt++;
        wait_done(50, cyc);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL dly_done got=%b exp=1", done);
        else pass_cnt++;
        total_cnt++;
        if (reads_issued - r0 != 1) $display("FAIL dly_reads got=%0d exp=1", reads_issued - r0);
        else pass_cnt++;
        total_cnt++;
        if (beats.size() != 1 || beats[0] !== {4'd5, 32'h105})
            $display("FAIL dly_beat got=%0d/%h exp=1/500000105", beats.size(),
                     (beats.size() > 0) ? beats[0] : 36'h0);
        else pass_cnt++;
        @(negedge clk);
        mode = 1'b0;
    endtask

    task automatic test_ignored_start();
        int cyc;
        int bc;
        int d0;
        logic [ADDR_W-1:0] a;
        beats.delete();
        d0 = done_cnt;
        do_start(4'd0, 4'd3);
        cyc = 1;
        bc = (busy === 1'b1) ? 1 : 0;
        first_addr = 4'd8;
        last_addr  = 4'd9;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 50) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if (cyc != 7) $display("FAIL ign_latency got=%0d exp=7", cyc);
        else pass_cnt++;
        total_cnt++;
        if (bc != 6) $display("FAIL ign_busy_cycles got=%0d exp=6", bc);
        else pass_cnt++;
        first_addr = 4'd10;
        last_addr  = 4'd10;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            total_cnt++;
            if ({busy, done, read_addr_valid} !== 3'b000)
                $display("FAIL ign_done_start got=%b exp=000", {busy, done, read_addr_valid});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (beats.size() != 4) $display("FAIL ign_beat_count got=%0d exp=4", beats.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            a = 4'(i);
            total_cnt++;
            if (beats[i] !== {a, 32'h100 + {28'h0, a}})
                $display("FAIL ign_beat%0d got=%h exp=%h", i, beats[i], {a, 32'h100 + {28'h0, a}});
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL ign_done_count got=%0d exp=1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        int n;
        logic [ADDR_W-1:0] a;
        beats.delete();
        mode = 1'b0;
        out_ready = 1'b1;
        do_start(4'd0, 4'd15);
        n = 0;
        while (beats.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (beats.size() < 3) $display("FAIL rst_mid_progress got=%0d exp>=3", beats.size());
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, read_addr_valid, read_data_ready, out_valid} !== 5'b0)
            $display("FAIL rst_mid_ctrl got=%b exp=00000",
                     {busy, done, read_addr_valid, read_data_ready, out_valid});
        else pass_cnt++;
        total_cnt++;
        if ({out_addr, out_data, read_addr_bits} !== 40'h0)
            $display("FAIL rst_mid_data got=%h exp=0", {out_addr, out_data, read_addr_bits});
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        beats.delete();
        do_start(4'd2, 4'd3);
        wait_done(50, cyc);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL rst_mid_done got=%b exp=1", done);
        else pass_cnt++;
        total_cnt++;
        if (beats.size() != 2) $display("FAIL rst_mid_beat_count got=%0d exp=2", beats.size());
        else pass_cnt++;
        for (int i = 0; i < 2 && i < beats.size(); i++) begin
            a = 4'(2 + i);
            total_cnt++;
            if (beats[i] !== {a, 32'h100 + {28'h0, a}})
                $display("FAIL rst_mid_beat%0d got=%h exp=%h", i, beats[i], {a, 32'h100 + {28'h0, a}});
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_wrap();
        test_backpressure();
        test_delay();
        test_ignored_start();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
